// File: rtl/cache_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types -- types shared by the mp2 memory-side blocks.
//
// The package keeps the historical name rv32i_types because the rest of the
// mp2 hierarchy imports it under that name. It holds the machine word and
// cache-line types used on the L1/ewb ports, plus the encodings used by
// cache_arbiter for its FSM state, its round-robin grant record and the
// latched operation of the transaction in flight.
// -----------------------------------------------------------------------------
package rv32i_types;

   localparam int RV32I_WORD_WIDTH = 32;
   localparam int RV32I_LINE_WIDTH = 256;

   typedef logic [RV32I_WORD_WIDTH-1:0] rv32i_word;
   typedef logic [RV32I_LINE_WIDTH-1:0] rv32i_cache_line;

   // Arbiter FSM. DONE is a one-cycle guard between a completion and the next
   // arbitration so that a request still held after its resp is not re-served.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   // Which requester won the most recent arbitration.
   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } arb_grant_t;

   // Operation latched at grant time.
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } arb_op_t;

endpackage : rv32i_types

// File: rtl/cache_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_arbiter_if -- signal bundle for hooking cache_arbiter into a system.
//
// Groups the I-cache, D-cache and downstream (ewb) handshakes of the arbiter.
//   master : the environment around the arbiter -- both L1 caches and the
//            downstream memory. Drives requests, write data and the memory
//            response; observes the arbiter outputs.
//   slave  : the arbiter's own view of the same signals.
// Clock and reset are not part of the bundle; they stay plain ports.
// -----------------------------------------------------------------------------
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);

   // I-cache side
   logic [ADDR_WIDTH-1:0] i_mem_address;
   logic                  i_mem_read;
   logic [LINE_WIDTH-1:0] i_mem_rdata;
   logic                  i_mem_resp;

   // D-cache side
   logic [ADDR_WIDTH-1:0] d_mem_address;
   logic                  d_mem_read;
   logic                  d_mem_write;
   logic [LINE_WIDTH-1:0] d_mem_wdata;
   logic [LINE_WIDTH-1:0] d_mem_rdata;
   logic                  d_mem_resp;

   // Downstream (ewb) side
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic                  pmem_read;
   logic                  pmem_write;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport master (
      output i_mem_address, i_mem_read,
      output d_mem_address, d_mem_read, d_mem_write, d_mem_wdata,
      output pmem_rdata, pmem_resp,
      input  i_mem_rdata, i_mem_resp,
      input  d_mem_rdata, d_mem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata
   );

   modport slave (
      input  i_mem_address, i_mem_read,
      input  d_mem_address, d_mem_read, d_mem_write, d_mem_wdata,
      input  pmem_rdata, pmem_resp,
      output i_mem_rdata, i_mem_resp,
      output d_mem_rdata, d_mem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata
   );

endinterface : cache_arbiter_if

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter -- shares one downstream line port between split I/D L1 caches.
//
// Sits between the I-cache, the D-cache and the ewb in the mp2 top level. One
// line transaction is in flight at a time. A lone requester is granted
// directly; when both request in the same IDLE cycle the one that did not win
// last time is granted (round-robin), so neither side can starve.
//
// Ports (flat, so the mp2 top level can wire it directly; cache_arbiter_if
// carries the same signal set for environments that prefer a bundle):
//   clk, rst                      clock, synchronous active-high reset
//   i_mem_address / i_mem_read    I-cache line read request (held until resp)
//   i_mem_rdata / i_mem_resp      line and one-cycle completion to the I-cache
//   d_mem_address / d_mem_read /
//   d_mem_write / d_mem_wdata     D-cache line request (held until resp)
//   d_mem_rdata / d_mem_resp      line and one-cycle completion to the D-cache
//   pmem_address / pmem_read /
//   pmem_write / pmem_wdata       downstream request
//   pmem_rdata / pmem_resp        downstream read line and completion
//
// Timing: grant in cycle N, downstream strobe from cycle N+1 until the cycle
// pmem_resp arrives; that resp is routed to the owner in the same cycle. One
// DONE cycle follows, then IDLE.
// -----------------------------------------------------------------------------
module cache_arbiter
   import rv32i_types::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [ADDR_WIDTH-1:0] i_mem_address,
   input  logic                  i_mem_read,
   output logic [LINE_WIDTH-1:0] i_mem_rdata,
   output logic                  i_mem_resp,

   input  logic [ADDR_WIDTH-1:0] d_mem_address,
   input  logic                  d_mem_read,
   input  logic                  d_mem_write,
   input  logic [LINE_WIDTH-1:0] d_mem_wdata,
   output logic [LINE_WIDTH-1:0] d_mem_rdata,
   output logic                  d_mem_resp,

   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   arb_state_t            state_r;
   arb_grant_t            last_grant;
   arb_op_t               op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;

   logic                  i_req_s;
   logic                  d_req_s;
   logic                  pick_d_s;

   // Request decode and round-robin choice used only when the FSM is in IDLE.
   always_comb begin
      i_req_s  = i_mem_read;
      d_req_s  = d_mem_read | d_mem_write;
      pick_d_s = 1'b0;
      if (d_req_s && !i_req_s) begin
         pick_d_s = 1'b1;
      end else if (d_req_s && i_req_s) begin
         // Tie: serve whoever did not win the previous arbitration.
         pick_d_s = (last_grant == GRANT_I);
      end else begin
         pick_d_s = 1'b0;
      end
   end

   // Arbiter FSM together with the grant record and the latched transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         last_grant <= GRANT_I;
         op_q       <= OP_READ;
         addr_q     <= {ADDR_WIDTH{1'b0}};
         wdata_q    <= {LINE_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               // pmem_resp is deliberately not looked at here.
               if (i_req_s || d_req_s) begin
                  if (pick_d_s) begin
                     state_r    <= D_BUSY;
                     last_grant <= GRANT_D;
                     addr_q     <= d_mem_address;
                     wdata_q    <= d_mem_wdata;
                     // A request showing both read and write is a write.
                     op_q       <= d_mem_write ? OP_WRITE : OP_READ;
                  end else begin
                     state_r    <= I_BUSY;
                     last_grant <= GRANT_I;
                     addr_q     <= i_mem_address;
                     wdata_q    <= {LINE_WIDTH{1'b0}};
                     op_q       <= OP_READ;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            I_BUSY, D_BUSY: begin
               // Request inputs are ignored while busy; only the completion
               // moves the FSM on, and there is no timeout.
               if (pmem_resp) begin
                  state_r <= DONE;
               end else begin
                  state_r <= state_r;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Downstream strobes come straight from the state and the latched op;
   // the I side can only ever produce reads.
   always_comb begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      case (state_r)
         I_BUSY: begin
            pmem_read  = 1'b1;
            pmem_write = 1'b0;
         end
         D_BUSY: begin
            pmem_read  = (op_q == OP_READ);
            pmem_write = (op_q == OP_WRITE);
         end
         default: begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
         end
      endcase
   end

   // Datapath to the ewb is taken only from the grant-time copies.
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   // Read data is broadcast; the resp pulse alone tells each cache it is theirs.
   assign i_mem_rdata  = pmem_rdata;
   assign d_mem_rdata  = pmem_rdata;
   assign i_mem_resp   = pmem_resp & (state_r == I_BUSY);
   assign d_mem_resp   = pmem_resp & (state_r == D_BUSY);

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
   import rv32i_types::*;

   localparam int AW = 32;
   localparam int LW = 256;
   localparam logic [AW-1:0] I_ADDR = 32'h0000_0080;
   localparam logic [AW-1:0] D_ADDR = 32'h0000_2040;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_mem_address (bus.i_mem_address),
      .i_mem_read    (bus.i_mem_read),
      .i_mem_rdata   (bus.i_mem_rdata),
      .i_mem_resp    (bus.i_mem_resp),
      .d_mem_address (bus.d_mem_address),
      .d_mem_read    (bus.d_mem_read),
      .d_mem_write   (bus.d_mem_write),
      .d_mem_wdata   (bus.d_mem_wdata),
      .d_mem_rdata   (bus.d_mem_rdata),
      .d_mem_resp    (bus.d_mem_resp),
      .pmem_address  (bus.pmem_address),
      .pmem_read     (bus.pmem_read),
      .pmem_write    (bus.pmem_write),
      .pmem_wdata    (bus.pmem_wdata),
      .pmem_rdata    (bus.pmem_rdata),
      .pmem_resp     (bus.pmem_resp)
   );

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic          is_d;
      logic [LW-1:0] rdata;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic          is_d;
      logic          rd;
      logic          wr;
      logic          hold;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
      int            lat;
      logic          exp_rd;
      logic          exp_wr;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic check_strobes(input string name, input logic rd, input logic wr);
      check({name, "_rd"}, LW'(bus.pmem_read), LW'(rd));
      check({name, "_wr"}, LW'(bus.pmem_write), LW'(wr));
   endtask

   task automatic idle_inputs();
      bus.i_mem_address = '0;
      bus.i_mem_read    = 1'b0;
      bus.d_mem_address = '0;
      bus.d_mem_read    = 1'b0;
      bus.d_mem_write   = 1'b0;
      bus.d_mem_wdata   = '0;
      bus.pmem_rdata    = '0;
      bus.pmem_resp     = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic is_d, input logic rd, input logic wr, input logic hold,
                               input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                               input logic [LW-1:0] rdata, input int lat,
                               input logic exp_rd, input logic exp_wr);
      vec_t v;
      v.is_d = is_d; v.rd = rd; v.wr = wr; v.hold = hold; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.lat = lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
      return v;
   endfunction

   // Scoreboard consumer: every resp pulse must match the oldest expected one.
   always @(negedge clk) begin
      if (bus.i_mem_resp === 1'b1 || bus.d_mem_resp === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_resp", LW'({bus.i_mem_resp, bus.d_mem_resp}), '0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("resp_i", LW'(bus.i_mem_resp), LW'(!e.is_d));
            check("resp_d", LW'(bus.d_mem_resp), LW'(e.is_d));
            check("resp_rdata", e.is_d ? bus.d_mem_rdata : bus.i_mem_rdata, e.rdata);
         end
      end
   end

   // One request from one side, with a chosen response latency.
   task automatic run_txn(input vec_t v, input int idx);
      sb_t e;
      string nm;
      nm = $sformatf("v%0d", idx);
      tick();
      if (v.is_d) begin
         bus.d_mem_address = v.addr;
         bus.d_mem_read    = v.rd;
         bus.d_mem_write   = v.wr;
         bus.d_mem_wdata   = v.wdata;
      end else begin
         bus.i_mem_address = v.addr;
         bus.i_mem_read    = 1'b1;
      end
      e.is_d  = v.is_d;
      e.rdata = v.rdata;
      sb_q.push_back(e);
      smp();
      check_strobes({nm, "_arb_latency"}, 1'b0, 1'b0);
      for (int c = 1; c <= v.lat; c++) begin
         tick();
         if (c == 2) begin
            // Inputs wander while busy; the latched copy must win.
            bus.i_mem_address = ~v.addr;
            bus.d_mem_address = ~v.addr;
            bus.d_mem_wdata   = ~v.wdata;
         end
         if (c == v.lat) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = v.rdata;
         end
         smp();
         check_strobes({nm, "_busy"}, v.exp_rd, v.exp_wr);
         check({nm, "_busy_addr"}, LW'(bus.pmem_address), LW'(v.addr));
         if (v.exp_wr) check({nm, "_busy_wdata"}, bus.pmem_wdata, v.wdata);
      end
      tick();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      if (!v.hold) idle_inputs();
      smp();
      check_strobes({nm, "_done"}, 1'b0, 1'b0);
      tick();
      idle_inputs();
      smp();
      check_strobes({nm, "_idle1"}, 1'b0, 1'b0);
      tick();
      smp();
      check_strobes({nm, "_idle2"}, 1'b0, 1'b0);
      check({nm, "_sb_drained"}, LW'(sb_q.size()), '0);
   endtask

   // Wait (bounded) for the next downstream strobe, then complete it.
   task automatic serve(input string name, input logic exp_d, input logic [LW-1:0] rdata, input int exp_wait);
      int   waited;
      logic seen;
      sb_t  e;
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 12) begin
         tick();
         waited++;
         smp();
         if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) seen = 1'b1;
      end
      check({name, "_seen"}, LW'(seen), LW'(1'b1));
      check({name, "_wait"}, LW'(waited), LW'(exp_wait));
      check({name, "_addr"}, LW'(bus.pmem_address), LW'(exp_d ? D_ADDR : I_ADDR));
      if (seen) begin
         e.is_d  = exp_d;
         e.rdata = rdata;
         sb_q.push_back(e);
         tick();
         bus.pmem_resp  = 1'b1;
         bus.pmem_rdata = rdata;
         smp();
         tick();
         bus.pmem_resp  = 1'b0;
         bus.pmem_rdata = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();

      // Reset state
      do_reset();
      smp();
      check_strobes("reset", 1'b0, 1'b0);
      check("reset_iresp", LW'(bus.i_mem_resp), '0);
      check("reset_dresp", LW'(bus.d_mem_resp), '0);
      check("reset_addr", LW'(bus.pmem_address), '0);
      check("reset_wdata", bus.pmem_wdata, '0);

      // Tie after reset, then back-to-back ties: D, I, D, I
      tick();
      bus.i_mem_address = I_ADDR;
      bus.i_mem_read    = 1'b1;
      bus.d_mem_address = D_ADDR;
      bus.d_mem_read    = 1'b1;
      serve("tie0_d", 1'b1, {8{32'h1111_0001}}, 1);
      serve("tie1_i", 1'b0, {8{32'h2222_0002}}, 2);
      serve("tie2_d", 1'b1, {8{32'h3333_0003}}, 2);
      serve("tie3_i", 1'b0, {8{32'h4444_0004}}, 2);
      idle_inputs();
      tick();
      smp();
      check_strobes("tie_end_idle", 1'b0, 1'b0);
      check("tie_sb_drained", LW'(sb_q.size()), '0);

      // Single-requester table
      do_reset();
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, '0, {32{8'hA5}}, 5, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, {LW{1'b1}}, '0, 3, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, '0, {8{32'hDEAD_BEEF}}, 1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, {8{32'h0F0F_1234}}, '0, 2, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFC0, '0, {8{32'h5A5A_C3C3}}, 1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4040, '0, {8{32'h0123_4567}}, 4, 1'b1, 1'b0));
      for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i);

      // Reset in the middle of a D read, late resp afterwards
      tick();
      bus.d_mem_address = 32'h0000_5000;
      bus.d_mem_read    = 1'b1;
      tick();
      tick();
      smp();
      check_strobes("rstmid_busy", 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
      smp();
      check_strobes("rstmid_after", 1'b0, 1'b0);
      check("rstmid_addr", LW'(bus.pmem_address), '0);
      check("rstmid_wdata", bus.pmem_wdata, '0);
      tick();
      tick();
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = {8{32'hBAD0_BAD0}};
      smp();
      check("late_iresp", LW'(bus.i_mem_resp), '0);
      check("late_dresp", LW'(bus.d_mem_resp), '0);
      tick();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      smp();
      check_strobes("late_idle", 1'b0, 1'b0);

      // After the reset last_grant is back to I, so a tie goes to D again
      tick();
      bus.i_mem_address = I_ADDR;
      bus.i_mem_read    = 1'b1;
      bus.d_mem_address = D_ADDR;
      bus.d_mem_read    = 1'b1;
      serve("post_rst_tie_d", 1'b1, {8{32'h7777_0007}}, 1);
      idle_inputs();
      tick();
      tick();
      smp();
      check("final_sb_drained", LW'(sb_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cache_arbiter

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: width of all addresses.
REQ-002 The block SHALL have parameter LINE_WIDTH, default 256: cache-line data width.
REQ-003 The block SHALL have the following ports, in this order:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_mem_address  input  ADDR_WIDTH  I-cache line address.
- i_mem_read  input  1  I-cache line-read request, held until i_mem_resp.
- i_mem_rdata  output  LINE_WIDTH  line returned to I-cache.
- i_mem_resp  output  1  one-cycle completion pulse to I-cache.
- d_mem_address  input  ADDR_WIDTH  D-cache line address.
- d_mem_read  input  1  D-cache line-read request, held until d_mem_resp.
- d_mem_write  input  1  D-cache line-write request, held until d_mem_resp.
- d_mem_wdata  input  LINE_WIDTH  D-cache write line.
- d_mem_rdata  output  LINE_WIDTH  line returned to D-cache.
- d_mem_resp  output  1  one-cycle completion pulse to D-cache.
- pmem_address  output  ADDR_WIDTH  downstream address (to ewb).
- pmem_read  output  1  downstream read strobe.
- pmem_write  output  1  downstream write strobe.
- pmem_wdata  output  LINE_WIDTH  downstream write line.
- pmem_rdata  input  LINE_WIDTH  downstream read line.
- pmem_resp  input  1  downstream completion pulse.

Function
REQ-004 The block SHALL implement FSM states IDLE, I_BUSY, D_BUSY, DONE.
REQ-005 In IDLE, a request from exactly one requester SHALL grant that requester; the next state is I_BUSY or D_BUSY.
REQ-006 In IDLE, simultaneous I and D requests SHALL grant the requester not named by the last_grant register (round-robin).
REQ-007 The last_grant register SHALL update on every grant.
REQ-008 At grant, the block SHALL latch the requester's address into addr_q, D wdata into wdata_q, and the operation (read/write) into op_q.
- pmem_address and pmem_wdata SHALL be driven only from addr_q and wdata_q.
REQ-009 pmem_read/pmem_write SHALL be asserted combinationally from state and op_q while in I_BUSY/D_BUSY, and deasserted in all other states.
- Grant in cycle N -> strobe high in cycle N+1; one cycle of arbitration latency.
REQ-010 If d_mem_read and d_mem_write are both high at grant, the operation SHALL be taken as a write.
REQ-011 I_BUSY SHALL only ever issue reads; pmem_write SHALL never be high in I_BUSY.
REQ-012 pmem_rdata SHALL be forwarded combinationally to both i_mem_rdata and d_mem_rdata.
REQ-013 i_mem_resp SHALL equal pmem_resp AND (state==I_BUSY); d_mem_resp SHALL equal pmem_resp AND (state==D_BUSY).
REQ-014 On pmem_resp in a BUSY state, the next state SHALL be DONE.
REQ-015 DONE SHALL last exactly one cycle, ignore all requests, and then go to IDLE, so a stale held request is never re-granted.
REQ-016 pmem_resp SHALL be ignored in IDLE and DONE: no resp is routed and no state change occurs.
REQ-017 Request changes during BUSY SHALL have no effect; the latched transaction completes.
REQ-018 The arbiter SHALL have no timeout; a BUSY state holds until pmem_resp.

Reset
REQ-019 When rst is high at a clock edge, the block SHALL set state=IDLE, last_grant=I, addr_q=0, wdata_q=0, op_q=read.
- This applies mid-transaction.
REQ-020 In the cycle after reset, all outputs SHALL be 0: pmem_read, pmem_write, i_mem_resp, d_mem_resp; pmem_address=0; pmem_wdata=0.
REQ-021 A pmem_resp arriving after a mid-transaction reset SHALL be dropped per REQ-016.

Structure
REQ-022 The state enum arb_state_t SHALL live in the shared package rv32i_types, alongside rv32i_word and rv32i_cache_line, which the ports use.
REQ-023 The block SHALL be a single module with no sub-modules; the round-robin pick is inline logic.
REQ-024 The block SHALL be instantiated between split I/D L1 caches and ewb in the mp2 top level.

Verification
REQ-025 The bench SHALL cover each of the following scenarios:
- Single I read: i_mem_read, addr 0x0000_0040, in cycle 0; pmem_resp in cycle 5 with data 0xA5.. -> pmem_read high cycles 1-5, pmem_address=0x40, i_mem_resp pulse in cycle 5, d_mem_resp stays 0.
- D write: addr 0x0000_1000, wdata all-ones -> pmem_write high, pmem_wdata all-ones, pmem_read low; d_mem_resp with pmem_resp; DONE for 1 cycle.
- Tie after reset: I and D requests both in cycle 0 -> D granted first; I granted in the IDLE cycle after DONE; last grant served ends as I.
- Back-to-back ties: D granted, then I, then D again -> alternation, no starvation.
- Stale request: the requester holds i_mem_read one cycle past i_mem_resp -> DONE ignores it; no second pmem_read.
- Reset mid-op: rst in cycle 3 of a D read -> pmem_read low in cycle 4; a late pmem_resp in cycle 6 -> no *_resp output pulse, state stays IDLE.
